// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
//   Interrupt-acknowledge sequencer for an 8259-style interrupt controller.
//   Resolves the highest-priority unmasked request against the in-service
//   register, raises int_out, and walks the two-pulse INTA handshake:
//   the first pulse latches the level and moves it into service, the second
//   drives the vector byte {vector_base, level}. EOI commands retire ISR bits.
//
// Ports
//   clock               system clock, all state changes on its rising edge
//   reset_n             asynchronous active-low reset
//   interrupt_request   latched IRR levels, bit 0 highest priority
//   interrupt_mask      IMR, 1 = masked
//   inta_n              CPU acknowledge strobe, active low, asynchronous
//   vector_base         ICW2 bits T7..T3
//   eoi_valid           one-cycle EOI command strobe
//   eoi_specific        1 = specific EOI, 0 = non-specific
//   eoi_level           target level for a specific EOI
//   int_out             registered interrupt request to the CPU
//   in_service_register registered ISR
//   clear_request       one-cycle pulse clearing the acknowledged IRR bit
//   data_out            vector byte
//   data_out_enable     1 while the vector is driven
module pic_inta_sequencer #(
    parameter logic [2:0] VECTOR_SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request,
    input  logic [7:0] interrupt_mask,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] clear_request,
    output logic [7:0] data_out,
    output logic       data_out_enable
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACK1  = 2'd1;
    localparam logic [1:0] ST_WAIT2 = 2'd2;
    localparam logic [1:0] ST_ACK2  = 2'd3;

    // Returns {none, index}: none = 1 when no bit is set, otherwise index of
    // the lowest set bit (the highest priority level).
    function automatic logic [3:0] find_lowest(input logic [7:0] v);
        logic [3:0] r;
        r = 4'b1000;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = {1'b0, i[2:0]};
        end
        return r;
    endfunction

    logic [1:0] state;
    logic [2:0] level_p1;
    logic       inta_sync_p0;
    logic       inta_sync_p1;
    logic       inta_sync_p2;

    logic [7:0] pending;
    logic [3:0] cand;
    logic [3:0] isr_low;
    logic       int_cond;
    logic       inta_fall;
    logic       inta_rise;
    logic       ack_take;
    logic       ack_real;
    logic [7:0] isr_next;

    // Synchroniser stage boundary: p0/p1 resolve metastability, p2 holds the
    // previous synchronised level so edges are seen for exactly one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inta_sync_p0 <= 1'b1;
            inta_sync_p1 <= 1'b1;
            inta_sync_p2 <= 1'b1;
        end else begin
            inta_sync_p0 <= inta_n;
            inta_sync_p1 <= inta_sync_p0;
            inta_sync_p2 <= inta_sync_p1;
        end
    end

    assign inta_fall = inta_sync_p2 & ~inta_sync_p1;
    assign inta_rise = ~inta_sync_p2 & inta_sync_p1;

    assign pending  = interrupt_request & ~interrupt_mask;
    assign cand     = find_lowest(pending);
    assign isr_low  = find_lowest(in_service_register);
    // Fully nested: a candidate may interrupt only a strictly lower priority.
    assign int_cond = ~cand[3] & (isr_low[3] | (cand[2:0] < isr_low[2:0]));

    assign ack_take = (state == ST_IDLE) && inta_fall;
    assign ack_real = ack_take & ~cand[3];

    // EOI is applied before the acknowledge set, so a set of the same bit wins.
    always_comb begin
        isr_next = in_service_register;
        if (eoi_valid) begin
            if (eoi_specific) begin
                isr_next[eoi_level] = 1'b0;
            end else if (!isr_low[3]) begin
                isr_next[isr_low[2:0]] = 1'b0;
            end
        end
        if (ack_real) begin
            isr_next[cand[2:0]] = 1'b1;
        end
    end

    // Sequencer stage boundary: state, ISR, captured level and vector outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_IDLE;
            level_p1            <= 3'd0;
            int_out             <= 1'b0;
            in_service_register <= 8'h00;
            clear_request       <= 8'h00;
            data_out            <= 8'h00;
            data_out_enable     <= 1'b0;
        end else begin
            in_service_register <= isr_next;
            clear_request       <= 8'h00;
            int_out             <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (inta_fall) begin
                        state    <= ST_ACK1;
                        level_p1 <= cand[3] ? VECTOR_SPURIOUS_LEVEL : cand[2:0];
                        if (!cand[3]) begin
                            clear_request <= 8'h01 << cand[2:0];
                        end
                    end else begin
                        int_out <= int_cond;
                    end
                end
                ST_ACK1: begin
                    if (inta_rise) state <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (inta_fall) begin
                        state           <= ST_ACK2;
                        data_out        <= {vector_base, level_p1};
                        data_out_enable <= 1'b1;
                    end
                end
                default: begin
                    if (inta_rise) begin
                        state           <= ST_IDLE;
                        data_out        <= 8'h00;
                        data_out_enable <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
module tb_pic_inta_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] interrupt_request;
    logic [7:0] interrupt_mask;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] in_service_register;
    logic [7:0] clear_request;
    logic [7:0] data_out;
    logic       data_out_enable;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_vec_q[$];
    logic [7:0] exp_clr_q[$];

    pic_inta_sequencer dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .interrupt_request   (interrupt_request),
        .interrupt_mask      (interrupt_mask),
        .inta_n              (inta_n),
        .vector_base         (vector_base),
        .eoi_valid           (eoi_valid),
        .eoi_specific        (eoi_specific),
        .eoi_level           (eoi_level),
        .int_out             (int_out),
        .in_service_register (in_service_register),
        .clear_request       (clear_request),
        .data_out            (data_out),
        .data_out_enable     (data_out_enable)
    );

    always #5 clock = ~clock;

    // Output monitor: vectors and clear pulses are matched against the
    // expectations queued when each acknowledge was started.
    logic       prev_oe  = 1'b0;
    logic [7:0] prev_clr = 8'h00;
    always @(negedge clock) begin
        if (reset_n) begin
            if (data_out_enable && !prev_oe) begin
                total++;
                if (exp_vec_q.size() == 0) begin
                    bad++;
                    $display("FAIL vector_unexpected: data_out=%h with no expected vector", data_out);
                end else begin
                    logic [7:0] ev;
                    ev = exp_vec_q.pop_front();
                    if (data_out !== ev) begin
                        bad++;
                        $display("FAIL vector: data_out=%h expected=%h", data_out, ev);
                    end
                end
            end
            if (clear_request !== 8'h00) begin
                total++;
                if (prev_clr !== 8'h00) begin
                    bad++;
                    $display("FAIL clear_width: clear_request=%h held, expected one-cycle pulse", clear_request);
                end else if (exp_clr_q.size() == 0) begin
                    bad++;
                    $display("FAIL clear_unexpected: clear_request=%h expected=00", clear_request);
                end else begin
                    logic [7:0] ec;
                    ec = exp_clr_q.pop_front();
                    if (clear_request !== ec) begin
                        bad++;
                        $display("FAIL clear: clear_request=%h expected=%h", clear_request, ec);
                    end
                end
            end
        end
        prev_oe  = data_out_enable;
        prev_clr = clear_request;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        inta_n = 1'b0;
        tick(6);
        inta_n = 1'b1;
        tick(6);
    endtask

    task automatic wait_int(input logic want, input string name);
        int k;
        k = 0;
        while (int_out !== want && k < 20) begin
            tick(1);
            k++;
        end
        total++;
        if (int_out !== want) begin
            bad++;
            $display("FAIL %s: int_out=%b expected=%b", name, int_out, want);
        end
    endtask

    task automatic check8(input logic [7:0] act, input logic [7:0] exp, input string name);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send_eoi(input logic spec, input logic [2:0] lvl);
        eoi_valid    = 1'b1;
        eoi_specific = spec;
        eoi_level    = lvl;
        tick(1);
        eoi_valid    = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        check8({7'd0, int_out}, 8'h00, "reset_int_out");
        check8(in_service_register, 8'h00, "reset_isr");
        check8(clear_request, 8'h00, "reset_clear");
        check8(data_out, 8'h00, "reset_data_out");
        check8({7'd0, data_out_enable}, 8'h00, "reset_oe");
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        interrupt_request = 8'h08;
        interrupt_mask    = 8'h00;
        vector_base       = 5'b01000;
        wait_int(1'b1, "basic_int_high");
        exp_clr_q.push_back(8'h08);
        exp_vec_q.push_back(8'h43);
        inta_n = 1'b0;
        tick(6);
        check8(in_service_register, 8'h08, "basic_isr");
        check8({7'd0, int_out}, 8'h00, "basic_int_ack1");
        check8({7'd0, data_out_enable}, 8'h00, "basic_oe_ack1");
        inta_n = 1'b1;
        tick(6);
        pulse();
        check8(data_out, 8'h00, "basic_data_after");
        check8({7'd0, int_out}, 8'h00, "basic_int_after");
        interrupt_request = 8'h00;
        send_eoi(1'b1, 3'd3);
        check8(in_service_register, 8'h00, "basic_eoi");
    endtask

    task automatic test_priority_mask();
        interrupt_request = 8'h0C;
        interrupt_mask    = 8'h04;
        vector_base       = 5'b10101;
        wait_int(1'b1, "prio_int_high");
        exp_clr_q.push_back(8'h08);
        exp_vec_q.push_back({5'b10101, 3'b011});
        inta_n = 1'b0;
        tick(6);
        // Late IRR/IMR changes must not alter the captured level.
        interrupt_request = 8'h01;
        interrupt_mask    = 8'h00;
        inta_n = 1'b1;
        tick(6);
        pulse();
        check8(in_service_register, 8'h08, "prio_isr");
        interrupt_request = 8'h00;
        send_eoi(1'b0, 3'd0);
        check8(in_service_register, 8'h00, "prio_eoi");
    endtask

    task automatic test_nesting_and_eoi();
        vector_base = 5'b01000;
        interrupt_request = 8'h04;
        wait_int(1'b1, "nest_int_l2");
        exp_clr_q.push_back(8'h04);
        exp_vec_q.push_back(8'h42);
        pulse();
        pulse();
        check8(in_service_register, 8'h04, "nest_isr_04");
        interrupt_request = 8'h10;
        tick(4);
        check8({7'd0, int_out}, 8'h00, "nest_int_blocked");
        interrupt_request = 8'h01;
        wait_int(1'b1, "nest_int_l0");
        exp_clr_q.push_back(8'h01);
        exp_vec_q.push_back(8'h40);
        pulse();
        pulse();
        check8(in_service_register, 8'h05, "nest_isr_05");
        interrupt_request = 8'h00;
        send_eoi(1'b0, 3'd5);
        check8(in_service_register, 8'h04, "eoi_nonspecific");
        send_eoi(1'b1, 3'd2);
        check8(in_service_register, 8'h00, "eoi_specific");
        send_eoi(1'b0, 3'd0);
        check8(in_service_register, 8'h00, "eoi_nonspecific_empty");
    endtask

    task automatic test_eoi_collision();
        interrupt_request = 8'h08;
        vector_base       = 5'b01000;
        wait_int(1'b1, "coll_int_high");
        exp_clr_q.push_back(8'h08);
        exp_vec_q.push_back(8'h43);
        inta_n = 1'b0;
        tick(2);
        eoi_valid    = 1'b1;
        eoi_specific = 1'b1;
        eoi_level    = 3'd3;
        tick(1);
        eoi_valid    = 1'b0;
        tick(3);
        check8(in_service_register, 8'h08, "coll_set_wins");
        inta_n = 1'b1;
        tick(6);
        pulse();
        interrupt_request = 8'h00;
        send_eoi(1'b1, 3'd3);
    endtask

    task automatic test_spurious();
        interrupt_request = 8'h20;
        vector_base       = 5'b00011;
        wait_int(1'b1, "spur_int_high");
        interrupt_request = 8'h00;
        exp_vec_q.push_back({5'b00011, 3'b111});
        pulse();
        check8(in_service_register, 8'h00, "spur_isr");
        pulse();
    endtask

    task automatic test_reset_in_wait2();
        interrupt_request = 8'h02;
        vector_base       = 5'b01000;
        wait_int(1'b1, "rst_int_high");
        exp_clr_q.push_back(8'h02);
        pulse();
        reset_n = 1'b0;
        tick(2);
        check8(in_service_register, 8'h00, "rst_isr");
        check8({7'd0, int_out}, 8'h00, "rst_int_out");
        check8(data_out, 8'h00, "rst_data_out");
        check8({7'd0, data_out_enable}, 8'h00, "rst_oe");
        reset_n = 1'b1;
        wait_int(1'b1, "rst_int_again");
        exp_clr_q.push_back(8'h02);
        exp_vec_q.push_back(8'h41);
        pulse();
        pulse();
        check8(in_service_register, 8'h02, "rst_isr_after");
        interrupt_request = 8'h00;
        send_eoi(1'b0, 3'd0);
    endtask

    initial begin
        reset_n           = 1'b0;
        interrupt_request = 8'h00;
        interrupt_mask    = 8'h00;
        inta_n            = 1'b1;
        vector_base       = 5'd0;
        eoi_valid         = 1'b0;
        eoi_specific      = 1'b0;
        eoi_level         = 3'd0;
        test_reset();
        test_basic();
        test_priority_mask();
        test_nesting_and_eoi();
        test_eoi_collision();
        test_spurious();
        test_reset_in_wait2();
        tick(3);
        total++;
        if (exp_vec_q.size() != 0 || exp_clr_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: vectors=%0d clears=%0d expected=0", exp_vec_q.size(), exp_clr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
